// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared Wishbone width defaults and the round-robin winner
//             function used by bus arbiters.
//  Contents : WB_ADDR_WIDTH, WB_DATA_WIDTH  - default bus widths
//             WB_MAX_MASTERS                - widest request vector handled
//             rr_next(req, last, n)         - one-hot round-robin winner
//  Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int WB_ADDR_WIDTH  = 20;
  localparam int WB_DATA_WIDTH  = 8;
  localparam int WB_MAX_MASTERS = 8;
  localparam int WB_IDX_WIDTH   = 3;

  // Returns the first requester strictly after the one-hot 'last' position,
  // wrapping around within the low 'n' bits. All zeros when nobody requests.
  // 'n' must be in 1..WB_MAX_MASTERS.
  function automatic logic [WB_MAX_MASTERS-1:0] rr_next(
    input logic [WB_MAX_MASTERS-1:0] req,
    input logic [WB_MAX_MASTERS-1:0] last,
    input int                        n
  );
    logic [WB_IDX_WIDTH-1:0] last_i;
    logic [WB_IDX_WIDTH-1:0] idx;
    logic                    found;
    rr_next = '0;
    last_i  = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < WB_MAX_MASTERS; i++) begin
      if (last[i]) last_i = WB_IDX_WIDTH'(i);
    end
    // Offsets 1..n visit every master once, ending on 'last' itself.
    for (int k = 1; k <= WB_MAX_MASTERS; k++) begin
      if (k <= n && !found) begin
        idx = WB_IDX_WIDTH'((int'(last_i) + k) % n);
        if (req[idx]) begin
          rr_next[idx] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
//  Module   : rr_select
//  Purpose  : Combinational round-robin priority picker.
//  Ports    : i_req   [N-1:0] - request vector
//             i_last  [N-1:0] - one-hot position of the previous winner
//             o_grant [N-1:0] - one-hot winner (zero when no request)
//             o_any           - at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module rr_select
  import wb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_last,
  output logic [N-1:0] o_grant,
  output logic         o_any
);

  logic [WB_MAX_MASTERS-1:0] w_grant_full;

  assign w_grant_full = rr_next(WB_MAX_MASTERS'(i_req), WB_MAX_MASTERS'(i_last), N);
  assign o_grant      = w_grant_full[N-1:0];
  assign o_any        = |w_grant_full;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Round-robin Wishbone B4 pipelined arbiter sharing one target bus
//             among NUM_MASTERS initiators, with a no-ack watchdog.
//  Ports    : wb_clock_i, wb_reset_n_i      - clock, async active-low reset
//             m_addr_i/m_data_i             - packed per-master addr/wdata
//             m_we_i/m_cycle_i/m_strobe_i   - per-master controls
//             m_data_o                      - read data, all masters
//             m_stall_o/m_ack_o/m_err_o     - per-master responses
//             s_addr_o/s_data_o/s_we_o/
//             s_cycle_o/s_strobe_o          - target request lanes
//             s_data_i/s_stall_i/s_ack_i    - target responses
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              wb_clock_i,
  input  logic                              wb_reset_n_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0]            m_cycle_i,
  input  logic [NUM_MASTERS-1:0]            m_strobe_i,
  output logic [DATA_WIDTH-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]            m_stall_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic [DATA_WIDTH-1:0]             s_data_o,
  output logic                              s_we_o,
  output logic                              s_cycle_o,
  output logic                              s_strobe_o,
  input  logic [DATA_WIDTH-1:0]             s_data_i,
  input  logic                              s_stall_i,
  input  logic                              s_ack_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]       c_TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]       c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]       c_CNT_MAX  = {CNT_W{1'b1}};
  // Pointer starts on the highest master so master 0 wins first.
  localparam logic [NUM_MASTERS-1:0] c_LAST_RST = {1'b1, {(NUM_MASTERS-1){1'b0}}};

  logic                   r_grant_valid;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] r_last;
  logic [CNT_W-1:0]       r_outstanding;
  logic [CNT_W-1:0]       r_wd_count;
  logic                   r_aborted;

  logic [NUM_MASTERS-1:0] w_winner;
  logic                   w_any;
  logic                   w_owner_cyc;
  logic                   w_arb;
  logic                   w_issue;
  logic                   w_ack_ok;
  logic                   w_retire;
  logic                   w_timeout;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0]  w_data;

  rr_select #(
    .N (NUM_MASTERS)
  ) u_rr_select (
    .i_req   (m_cycle_i),
    .i_last  (r_last),
    .o_grant (w_winner),
    .o_any   (w_any)
  );

  // Ownership lasts exactly as long as the owner holds cycle; a new winner is
  // picked on the same edge the owner is seen low, so handoff needs no idle.
  assign w_owner_cyc = r_grant_valid & (|(r_grant & m_cycle_i));
  assign w_arb       = ~w_owner_cyc;

  // One-hot AND-OR mux of the owner's lanes; all zeros with no owner.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) begin
        w_addr = w_addr | m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_data = w_data | m_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign s_addr_o   = w_addr;
  assign s_data_o   = w_data;
  assign s_cycle_o  = w_owner_cyc & ~r_aborted;
  assign s_strobe_o = s_cycle_o & (|(r_grant & m_strobe_i));
  assign s_we_o     = r_grant_valid & (|(r_grant & m_we_i));
  assign m_data_o   = s_data_i;

  assign w_issue  = s_strobe_o & ~s_stall_i;
  // Acks with no owner or after an abort belong to nobody.
  assign w_ack_ok = s_ack_i & r_grant_valid & ~r_aborted;
  assign w_retire = w_ack_ok & (r_outstanding != '0);
  // An ack landing on the expiry cycle wins over the error.
  assign w_timeout = r_grant_valid & ~r_aborted & ~s_ack_i & (r_wd_count == c_TIMEOUT);

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
      logic w_own;
      assign w_own         = r_grant_valid & r_grant[gi];
      assign m_stall_o[gi] = w_own ? (s_stall_i | r_aborted) : 1'b1;
      assign m_ack_o[gi]   = w_own & w_ack_ok;
      assign m_err_o[gi]   = w_own & w_timeout;
    end
  endgenerate

  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      r_grant_valid <= 1'b0;
      r_grant       <= '0;
      r_last        <= c_LAST_RST;
      r_outstanding <= '0;
      r_wd_count    <= '0;
      r_aborted     <= 1'b0;
    end else if (w_arb) begin
      r_grant_valid <= w_any;
      r_grant       <= w_winner;
      if (w_any) r_last <= w_winner;
      r_outstanding <= '0;
      r_wd_count    <= '0;
      r_aborted     <= 1'b0;
    end else if (r_aborted) begin
      r_outstanding <= '0;
      r_wd_count    <= '0;
    end else if (w_timeout) begin
      r_aborted     <= 1'b1;
      r_outstanding <= '0;
      r_wd_count    <= '0;
    end else begin
      if (w_issue && !w_retire && r_outstanding != c_CNT_MAX) begin
        r_outstanding <= r_outstanding + c_ONE;
      end else if (w_retire && !w_issue) begin
        r_outstanding <= r_outstanding - c_ONE;
      end
      if (w_ack_ok) begin
        r_wd_count <= '0;
      end else if (r_outstanding != '0) begin
        r_wd_count <= r_wd_count + c_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Purpose  : Directed self-checking bench for wb_arbiter (2 masters,
//             20-bit address, 8-bit data, 8-cycle watchdog).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int NM = 2;
  localparam int AW = 20;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM*AW-1:0]  m_addr = '0;
  logic [NM*DW-1:0]  m_data = '0;
  logic [NM-1:0]     m_we = '0;
  logic [NM-1:0]     m_cyc = '0;
  logic [NM-1:0]     m_stb = '0;
  logic [DW-1:0]     m_data_o;
  logic [NM-1:0]     m_stall_o;
  logic [NM-1:0]     m_ack_o;
  logic [NM-1:0]     m_err_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_data_o;
  logic              s_we_o;
  logic              s_cycle_o;
  logic              s_strobe_o;
  logic [DW-1:0]     s_data_i = '0;
  logic              s_stall = 1'b0;
  logic              s_ack = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  wb_arbiter #(
    .NUM_MASTERS    (NM),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clock_i   (clk),
    .wb_reset_n_i (rst_n),
    .m_addr_i     (m_addr),
    .m_data_i     (m_data),
    .m_we_i       (m_we),
    .m_cycle_i    (m_cyc),
    .m_strobe_i   (m_stb),
    .m_data_o     (m_data_o),
    .m_stall_o    (m_stall_o),
    .m_ack_o      (m_ack_o),
    .m_err_o      (m_err_o),
    .s_addr_o     (s_addr_o),
    .s_data_o     (s_data_o),
    .s_we_o       (s_we_o),
    .s_cycle_o    (s_cycle_o),
    .s_strobe_o   (s_strobe_o),
    .s_data_i     (s_data_i),
    .s_stall_i    (s_stall),
    .s_ack_i      (s_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_stall = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int cnt;
    int e;
    int acks;
    int peak;

    // ---------------- reset values ----------------
    #1;
    check_eq("rst_cyc",   s_cycle_o,  0);
    check_eq("rst_stb",   s_strobe_o, 0);
    check_eq("rst_we",    s_we_o,     0);
    check_eq("rst_stall", m_stall_o,  2'b11);
    check_eq("rst_ack",   m_ack_o,    0);
    check_eq("rst_err",   m_err_o,    0);
    #10;
    rst_n = 1'b1;
    step();

    // ---------------- master 0 single write ----------------
    m_addr[19:0] = 20'h12345; m_data[7:0] = 8'hA5;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    #1;
    check_eq("wr_latency_cyc",   s_cycle_o, 0);
    check_eq("wr_latency_stall", m_stall_o, 2'b11);
    step();
    check_eq("wr_cyc",   s_cycle_o,  1);
    check_eq("wr_stb",   s_strobe_o, 1);
    check_eq("wr_we",    s_we_o,     1);
    check_eq("wr_addr",  s_addr_o,   20'h12345);
    check_eq("wr_data",  s_data_o,   8'hA5);
    check_eq("wr_stall", m_stall_o,  2'b10);
    step();
    m_stb[0] = 1'b0; s_ack = 1'b1;
    #1;
    check_eq("wr_ack",    m_ack_o,   2'b01);
    check_eq("wr_stall1", m_stall_o, 2'b10);
    step();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_we[0] = 1'b0;
    #1;
    check_eq("wr_end_cyc", s_cycle_o, 0);
    check_eq("wr_end_ack", m_ack_o,   0);
    step();

    // ---------------- round-robin alternation ----------------
    do_reset();
    m_addr[19:0] = 20'h00100; m_addr[39:20] = 20'h00200;
    m_cyc = 2'b11; m_stb = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = k % 2;
      cnt = 0;
      while (!s_cycle_o && cnt < 8) begin
        step();
        cnt++;
      end
      check_eq("rr_wait",  cnt, (k == 0) ? 1 : 0);
      check_eq("rr_owner", s_addr_o, (e == 1) ? 20'h00200 : 20'h00100);
      s_ack = 1'b1;
      #1;
      check_eq("rr_ack", m_ack_o, (e == 1) ? 2'b10 : 2'b01);
      step();
      s_ack = 1'b0; m_cyc[e] = 1'b0; m_stb[e] = 1'b0;
      if (k == 3) begin
        m_cyc = '0; m_stb = '0;
      end
      step();
      if (k < 3) begin
        m_cyc[e] = 1'b1; m_stb[e] = 1'b1;
      end
      #1;
    end
    step();

    // ---------------- master 1 read with target stall ----------------
    m_addr[39:20] = 20'h00400;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; s_stall = 1'b1;
    #1;
    check_eq("rd_wait_stall", m_stall_o, 2'b11);
    step();
    check_eq("rd_cyc",  s_cycle_o, 1);
    check_eq("rd_addr", s_addr_o,  20'h00400);
    check_eq("rd_we",   s_we_o,    0);
    for (int i = 0; i < 3; i++) begin
      check_eq("rd_stall_hi", m_stall_o, 2'b11);
      step();
    end
    s_stall = 1'b0;
    #1;
    check_eq("rd_stall_lo", m_stall_o, 2'b01);
    step();
    m_stb[1] = 1'b0; s_ack = 1'b1; s_data_i = 8'h5A;
    #1;
    check_eq("rd_ack",  m_ack_o,  2'b10);
    check_eq("rd_data", m_data_o, 8'h5A);
    step();
    s_ack = 1'b0; m_cyc = '0;
    step();

    // ---------------- pipelined burst, acks two cycles late ----------------
    m_addr[19:0] = 20'h00010; m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    #1;
    step();
    acks = 0; peak = 0;
    for (int i = 0; i < 5; i++) begin
      m_stb[0] = (i < 3);
      s_ack    = (i >= 2);
      #1;
      check_eq("burst_err", m_err_o, 0);
      if (m_ack_o[0]) acks++;
      if (int'(dut.r_outstanding) > peak) peak = int'(dut.r_outstanding);
      step();
    end
    s_ack = 1'b0;
    #1;
    check_eq("burst_acks", acks, 3);
    check_eq("burst_peak", peak, 2);
    check_eq("burst_out0", dut.r_outstanding, 0);
    m_cyc = '0; m_stb = '0; m_we = '0;
    step();

    // ---------------- watchdog abort ----------------
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1;
    step();
    check_eq("to_grant0", m_stall_o, 2'b10);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    m_stb[0] = 1'b0;
    #1;
    cnt = 0;
    while (!m_err_o[0] && cnt < 20) begin
      step();
      cnt++;
    end
    check_eq("to_delay",   cnt,       8);
    check_eq("to_err",     m_err_o,   2'b01);
    step();
    s_ack = 1'b1;
    #1;
    check_eq("to_cyc_low", s_cycle_o, 0);
    check_eq("to_err_end", m_err_o,   0);
    check_eq("to_late_ack", m_ack_o,  0);
    check_eq("to_stall",   m_stall_o, 2'b11);
    s_ack = 1'b0; m_cyc[0] = 1'b0;
    step();
    check_eq("to_m1_cyc",   s_cycle_o, 1);
    check_eq("to_m1_addr",  s_addr_o,  20'h00400);
    check_eq("to_m1_stall", m_stall_o, 2'b01);
    m_cyc = '0; m_stb = '0;
    step();

    // ---------------- async reset mid-transfer ----------------
    m_addr[19:0] = 20'h12345;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1;
    step();
    check_eq("ar_pre_cyc", s_cycle_o, 1);
    #2;
    s_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("ar_cyc",   s_cycle_o,  0);
    check_eq("ar_stb",   s_strobe_o, 0);
    check_eq("ar_stall", m_stall_o,  2'b11);
    check_eq("ar_ack",   m_ack_o,    0);
    check_eq("ar_err",   m_err_o,    0);
    s_ack = 1'b0; m_cyc = 2'b11; m_stb = 2'b11;
    #1;
    rst_n = 1'b1;
    step();
    check_eq("ar_prio_addr",  s_addr_o,  20'h12345);
    check_eq("ar_prio_stall", m_stall_o, 2'b10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard stop in case a stimulus step ever stalls.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
